// File: rtl/overture_pkg.sv
// Shared types and constants for the overture lock environment.
// Feedback codes, CPU opcode fields and lock state encoding.
package overture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_SOLVED,
    ST_LOCKED
  } lock_state_t;

  localparam logic [7:0] FB_LOW    = 8'h00;
  localparam logic [7:0] FB_HIGH   = 8'h01;
  localparam logic [7:0] FB_MATCH  = 8'h02;
  localparam logic [7:0] FB_LOCKED = 8'h03;
  localparam logic [7:0] FB_NONE   = 8'hFF;

  localparam logic [2:0] OUT_REG   = 3'b110;
  localparam logic [1:0] MOV_CLASS = 2'b10;

  function automatic logic [7:0] cmp_code(
    input logic [7:0] g,
    input logic [7:0] s
  );
    if (g < s)
      return FB_LOW;
    else if (g > s)
      return FB_HIGH;
    else
      return FB_MATCH;
  endfunction

  function automatic logic [7:0] sat_inc(
    input logic [7:0] v
  );
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/overture_lock_env_if.sv
// CPU-side bus between overture_cpu and the lock.
// master is the CPU side, slave is the lock side.
interface overture_lock_env_if;
  logic       run;
  logic [7:0] instr_debug;
  logic [7:0] out_port;
  logic [7:0] in_port;

  modport master (
    output run,
    output instr_debug,
    output out_port,
    input  in_port
  );

  modport slave (
    input  run,
    input  instr_debug,
    input  out_port,
    output in_port
  );
endinterface

// File: rtl/overture_out_snoop.sv
// Watches the CPU instruction stream for writes to OUT.
// Emits one wr_valid cycle per write, carrying out_port.
module overture_out_snoop
  import overture_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] instr_debug,
  input  logic [7:0] out_port,
  output logic       wr_valid,
  output logic [7:0] wr_data
);

  logic pend;
  logic hit;

  assign hit = run
    && (instr_debug[7:6] == MOV_CLASS)
    && (instr_debug[2:0] == OUT_REG);

  // OUT holds the new value one cycle after the instruction
  always_ff @(posedge clk) begin
    if (reset)
      pend <= 1'b0;
    else
      pend <= hit;
  end

  assign wr_valid = pend;
  assign wr_data  = out_port;

endmodule

// File: rtl/overture_lock_env.sv
// Guessing-game lock driven by the overture CPU OUT port.
// Feedback returns to the CPU through in_port.
module overture_lock_env
  import overture_pkg::*;
#(
  parameter int unsigned MAX_GUESSES = 8
) (
  input  logic       clk,
  input  logic       reset,
  overture_lock_env_if.slave cpu,
  input  logic [7:0] secret,
  input  logic       load_secret,
  output logic [7:0] guess_count,
  output logic [7:0] last_guess,
  output logic       solved,
  output logic       locked_out
);

  lock_state_t state, state_n;
  logic [7:0]  sec_q, sec_n;
  logic [7:0]  fb_q, fb_n;
  logic [7:0]  cnt_q, cnt_n;
  logic [7:0]  last_q, last_n;
  logic [7:0]  cnt_inc;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        eval;
  logic        hit_max;

  overture_out_snoop u_snoop (
    .clk         (clk),
    .reset       (reset),
    .run         (cpu.run),
    .instr_debug (cpu.instr_debug),
    .out_port    (cpu.out_port),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data)
  );

  assign cnt_inc = sat_inc(cnt_q);
  assign hit_max = (MAX_GUESSES != 0)
    && (32'(cnt_inc) == MAX_GUESSES);
  assign eval = wr_valid && !load_secret
    && (state == ST_ARMED);

  always_comb begin
    state_n = state;
    sec_n   = sec_q;
    fb_n    = fb_q;
    cnt_n   = cnt_q;
    last_n  = last_q;
    unique case (1'b1)
      load_secret: begin
        state_n = ST_ARMED;
        sec_n   = secret;
        fb_n    = FB_NONE;
        cnt_n   = 8'h00;
        last_n  = 8'h00;
      end
      eval: begin
        cnt_n  = cnt_inc;
        last_n = wr_data;
        fb_n   = cmp_code(wr_data, sec_q);
        if (wr_data == sec_q) begin
          state_n = ST_SOLVED;
        end else if (hit_max) begin
          state_n = ST_LOCKED;
          fb_n    = FB_LOCKED;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      sec_q      <= 8'h00;
      fb_q       <= FB_NONE;
      cnt_q      <= 8'h00;
      last_q     <= 8'h00;
      solved     <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      state      <= state_n;
      sec_q      <= sec_n;
      fb_q       <= fb_n;
      cnt_q      <= cnt_n;
      last_q     <= last_n;
      solved     <= (state_n == ST_SOLVED);
      locked_out <= (state_n == ST_LOCKED);
    end
  end

  assign cpu.in_port = fb_q;
  assign guess_count = cnt_q;
  assign last_guess  = last_q;

endmodule

// File: tb/tb_overture_lock_env.sv
// Table-driven bench for overture_lock_env with MAX_GUESSES=3.
// Expected rows are queued at stimulus and popped after evaluation.
module tb_overture_lock_env;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] secret;
  logic       load_secret;
  logic [7:0] guess_count;
  logic [7:0] last_guess;
  logic       solved;
  logic       locked_out;

  overture_lock_env_if bus ();

  overture_lock_env #(
    .MAX_GUESSES (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu         (bus),
    .secret      (secret),
    .load_secret (load_secret),
    .guess_count (guess_count),
    .last_guess  (last_guess),
    .solved      (solved),
    .locked_out  (locked_out)
  );

  always #5 clk = ~clk;

  typedef enum {
    OP_RST,
    OP_LOAD,
    OP_GUESS,
    OP_PAIR,
    OP_COLLIDE,
    OP_RSTPEND
  } op_t;

  typedef struct {
    op_t        op;
    logic [7:0] instr;
    logic       run;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] e_in;
    logic [7:0] e_cnt;
    logic [7:0] e_last;
    logic       e_sol;
    logic       e_lock;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(
    input op_t op, input logic [7:0] ins,
    input logic rn, input logic [7:0] d0,
    input logic [7:0] d1, input logic [7:0] ei,
    input logic [7:0] ec, input logic [7:0] el,
    input logic es, input logic elk
  );
    vec_t v;
    v.op = op; v.instr = ins; v.run = rn;
    v.d0 = d0; v.d1 = d1; v.e_in = ei;
    v.e_cnt = ec; v.e_last = el;
    v.e_sol = es; v.e_lock = elk;
    tbl.push_back(v);
  endfunction

  task automatic chk(
    input string name,
    input logic [7:0] act,
    input logic [7:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h",
        name, act, exp);
    end
  endtask

  task automatic cyc(
    input logic r, input logic ld,
    input logic rn, input logic [7:0] ins,
    input logic [7:0] od, input logic [7:0] sec
  );
    reset = r;
    load_secret = ld;
    bus.run = rn;
    bus.instr_debug = ins;
    bus.out_port = od;
    secret = sec;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string p, input vec_t e);
    chk({p, " in_port"}, bus.in_port, e.e_in);
    chk({p, " count"}, guess_count, e.e_cnt);
    chk({p, " last"}, last_guess, e.e_last);
    chk({p, " solved"}, 8'(solved), 8'(e.e_sol));
    chk({p, " locked"}, 8'(locked_out), 8'(e.e_lock));
  endtask

  initial begin
    vec_t       v;
    vec_t       e;
    logic [7:0] prev_in;
    logic [7:0] prev_cnt;
    string      p;

    reset = 1'b1;
    load_secret = 1'b0;
    secret = 8'h00;
    bus.run = 1'b0;
    bus.instr_debug = 8'h00;
    bus.out_port = 8'h00;

    add(OP_RST,     8'h00, 0, 8'h00, 8'h00, 8'hFF, 0, 8'h00, 0, 0);
    add(OP_GUESS,   8'h86, 1, 8'h10, 8'h00, 8'hFF, 0, 8'h00, 0, 0);
    add(OP_LOAD,    8'h00, 0, 8'h5A, 8'h00, 8'hFF, 0, 8'h00, 0, 0);
    add(OP_GUESS,   8'h86, 1, 8'h10, 8'h00, 8'h00, 1, 8'h10, 0, 0);
    add(OP_GUESS,   8'h86, 1, 8'hF0, 8'h00, 8'h01, 2, 8'hF0, 0, 0);
    add(OP_GUESS,   8'h86, 1, 8'h5A, 8'h00, 8'h02, 3, 8'h5A, 1, 0);
    add(OP_GUESS,   8'h86, 1, 8'h00, 8'h00, 8'h02, 3, 8'h5A, 1, 0);
    add(OP_LOAD,    8'h00, 0, 8'h07, 8'h00, 8'hFF, 0, 8'h00, 0, 0);
    add(OP_GUESS,   8'h86, 1, 8'h01, 8'h00, 8'h00, 1, 8'h01, 0, 0);
    add(OP_GUESS,   8'h85, 1, 8'h02, 8'h00, 8'h00, 1, 8'h01, 0, 0);
    add(OP_GUESS,   8'h86, 1, 8'h02, 8'h00, 8'h00, 2, 8'h02, 0, 0);
    add(OP_GUESS,   8'h86, 1, 8'h03, 8'h00, 8'h03, 3, 8'h03, 0, 1);
    add(OP_GUESS,   8'h86, 1, 8'h07, 8'h00, 8'h03, 3, 8'h03, 0, 1);
    add(OP_LOAD,    8'h00, 0, 8'h07, 8'h00, 8'hFF, 0, 8'h00, 0, 0);
    add(OP_GUESS,   8'h86, 1, 8'h01, 8'h00, 8'h00, 1, 8'h01, 0, 0);
    add(OP_GUESS,   8'h86, 1, 8'h02, 8'h00, 8'h00, 2, 8'h02, 0, 0);
    add(OP_GUESS,   8'h86, 1, 8'h07, 8'h00, 8'h02, 3, 8'h07, 1, 0);
    add(OP_LOAD,    8'h00, 0, 8'h5A, 8'h00, 8'hFF, 0, 8'h00, 0, 0);
    add(OP_PAIR,    8'h86, 1, 8'h20, 8'h21, 8'h00, 2, 8'h21, 0, 0);
    add(OP_LOAD,    8'h00, 0, 8'h5A, 8'h00, 8'hFF, 0, 8'h00, 0, 0);
    add(OP_PAIR,    8'h86, 0, 8'h20, 8'h21, 8'hFF, 0, 8'h00, 0, 0);
    add(OP_COLLIDE, 8'h86, 1, 8'h33, 8'h33, 8'hFF, 0, 8'h00, 0, 0);
    add(OP_GUESS,   8'h86, 1, 8'h33, 8'h00, 8'h02, 1, 8'h33, 1, 0);
    add(OP_RSTPEND, 8'h86, 1, 8'h33, 8'h00, 8'hFF, 0, 8'h00, 0, 0);
    add(OP_GUESS,   8'h86, 1, 8'h33, 8'h00, 8'hFF, 0, 8'h00, 0, 0);
    add(OP_LOAD,    8'h00, 0, 8'h80, 8'h00, 8'hFF, 0, 8'h00, 0, 0);
    add(OP_GUESS,   8'h8E, 1, 8'hFF, 8'h00, 8'h01, 1, 8'hFF, 0, 0);
    add(OP_GUESS,   8'hC6, 1, 8'h80, 8'h00, 8'h01, 1, 8'hFF, 0, 0);
    add(OP_GUESS,   8'h86, 1, 8'h7F, 8'h00, 8'h00, 2, 8'h7F, 0, 0);

    prev_in = 8'hFF;
    prev_cnt = 8'h00;

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      p = $sformatf("row%0d", i);
      case (v.op)
        OP_RST: begin
          sb.push_back(v);
          cyc(1, 0, 0, 8'h00, 8'h00, 8'h00);
        end
        OP_LOAD: begin
          sb.push_back(v);
          cyc(0, 1, 0, 8'h00, 8'h00, v.d0);
        end
        OP_GUESS: begin
          sb.push_back(v);
          cyc(0, 0, v.run, v.instr, 8'h00, 8'h00);
          chk({p, " latency"}, bus.in_port, prev_in);
          cyc(0, 0, 0, 8'h00, v.d0, 8'h00);
        end
        OP_PAIR: begin
          sb.push_back(v);
          cyc(0, 0, v.run, v.instr, 8'h00, 8'h00);
          cyc(0, 0, v.run, v.instr, v.d0, 8'h00);
          chk({p, " mid count"}, guess_count,
            v.run ? prev_cnt + 8'd1 : prev_cnt);
          cyc(0, 0, 0, 8'h00, v.d1, 8'h00);
        end
        OP_COLLIDE: begin
          sb.push_back(v);
          cyc(0, 0, v.run, v.instr, 8'h00, 8'h00);
          cyc(0, 1, 0, 8'h00, v.d0, v.d1);
        end
        default: begin
          sb.push_back(v);
          cyc(0, 0, v.run, v.instr, 8'h00, 8'h00);
          cyc(1, 0, 0, 8'h00, v.d0, 8'h00);
        end
      endcase
      if (sb.size() == 0) begin
        chk({p, " sb underflow"}, 8'h01, 8'h00);
      end else begin
        e = sb.pop_front();
        chk_all(p, e);
        cyc(0, 0, 0, 8'h00, 8'h5A, 8'h00);
        chk({p, " hold"}, bus.in_port, e.e_in);
        prev_in = e.e_in;
        prev_cnt = e.e_cnt;
      end
    end

    chk("sb empty", 8'(sb.size()), 8'h00);

    // reset beats a simultaneous load and a live OUT write
    cyc(0, 1, 0, 8'h00, 8'h00, 8'h11);
    cyc(0, 0, 1, 8'h86, 8'h00, 8'h00);
    cyc(1, 1, 1, 8'h86, 8'h44, 8'h44);
    chk("rst prio in_port", bus.in_port, 8'hFF);
    chk("rst prio count", guess_count, 8'h00);
    cyc(0, 0, 0, 8'h00, 8'h44, 8'h00);
    chk("rst prio pend", guess_count, 8'h00);
    cyc(0, 0, 1, 8'h86, 8'h00, 8'h00);
    cyc(0, 0, 0, 8'h00, 8'h44, 8'h00);
    chk("rst prio idle in", bus.in_port, 8'hFF);
    chk("rst prio idle sol", 8'(solved), 8'h00);
    chk("rst prio idle last", last_guess, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

endmodule

// File: doc/overture_lock_env.md
OVERTURE_LOCK_ENV -- requirements
Module: overture_lock_env

Interface
REQ-001 Parameter MAX_GUESSES, default 8, guesses allowed before lockout; 0 means unlimited.
REQ-002 Port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port run  input  1  CPU run enable, same signal fed to overture_cpu.
REQ-005 Port instr_debug  input  8  instruction byte currently executing in the CPU.
REQ-006 Port out_port  input  8  CPU output register value.
REQ-007 Port secret  input  8  combination to arm.
REQ-008 Port load_secret  input  1  one-cycle pulse; arms the lock with secret.
REQ-009 Port in_port  output  8  feedback byte driven to the CPU in_port.
REQ-010 Port guess_count  output  8  number of guesses evaluated since arming.
REQ-011 Port last_guess  output  8  most recently evaluated guess.
REQ-012 Port solved  output  1  high while in SOLVED.
REQ-013 Port locked_out  output  1  high while in LOCKED.

Function
REQ-014 Output-write detect: run=1 and instr_debug[7:6]=2'b10 and instr_debug[2:0]=3'b110 in cycle N shall set a write-pending flag at edge N.
REQ-015 A pending write shall sample out_port in cycle N+1, once only, and clear the flag at edge N+1.
REQ-016 Back-to-back output writes in consecutive cycles shall each produce one sample; no write is dropped.
REQ-017 run=0 shall suppress detection; an already pending sample shall still complete.
REQ-018 States: IDLE (unarmed), ARMED, SOLVED, LOCKED.
REQ-019 load_secret in any state shall latch secret, clear guess_count and last_guess to 0, set in_port to 8'hFF, enter ARMED, and discard any pending sample in that cycle.
REQ-020 In ARMED, a sample g shall increment guess_count (saturating at 255), set last_guess=g, and set in_port to 8'h00 if g<secret, 8'h01 if g>secret, 8'h02 if g==secret; comparison unsigned.
REQ-021 In ARMED, g==secret shall enter SOLVED at the same edge.
REQ-022 In ARMED, g!=secret with MAX_GUESSES!=0 and post-increment guess_count==MAX_GUESSES shall enter LOCKED and set in_port to 8'h03.
REQ-023 A correct guess on the final allowed attempt shall enter SOLVED, not LOCKED.
REQ-024 Samples in IDLE, SOLVED, or LOCKED shall be ignored; no output changes.
REQ-025 in_port, guess_count, last_guess, solved, locked_out shall be registered; latency from the output-instruction cycle to feedback visible is 2 edges.
REQ-026 Feedback shall hold until the next evaluated sample, load, or reset.

Reset
REQ-027 Reset shall force IDLE, secret register 8'h00, in_port 8'hFF, guess_count 0, last_guess 0, solved 0, locked_out 0, pending flag 0.
REQ-028 Reset shall take priority over load_secret and over a pending sample in the same cycle.
REQ-029 Reset asserted mid-sequence shall discard any pending write with no partial update.

Structure
REQ-030 Feedback codes (8'h00 LOW, 8'h01 HIGH, 8'h02 MATCH, 8'h03 LOCKED, 8'hFF NONE), the OUT register code 3'b110, the MOV class 2'b10, and the state enum shall live in shared package overture_pkg.
REQ-031 Write detection (REQ-014..017) shall be sub-module overture_out_snoop: inputs clk, reset, run, instr_debug, out_port; outputs wr_valid, wr_data.
REQ-032 Top-level shall connect to an overture_cpu instance only through in_port, out_port, instr_debug, and run.

Verification
REQ-033 Reset then load secret=8'h5A; instr_debug=8'h86 with out_port 8'h10 next cycle -> in_port=8'h00, guess_count=1, last_guess=8'h10 after 2 edges.
REQ-034 Armed 8'h5A; guesses 8'hF0, then 8'h5A -> in_port 8'h01 then 8'h02, solved=1, guess_count=2; a further guess 8'h00 -> nothing changes.
REQ-035 MAX_GUESSES=3, secret 8'h07; guesses 1, 2, 3 -> in_port=8'h03, locked_out=1 after third; guesses 1, 2, 7 -> solved=1, locked_out=0.
REQ-036 Two consecutive output instructions writing 8'h20, 8'h21 -> two evaluations, guess_count=2, last_guess=8'h21; same with run=0 -> guess_count=0.
REQ-037 load_secret=8'h33 in the same cycle a sample is due -> sample discarded, guess_count=0, in_port=8'hFF, ARMED with 8'h33.
REQ-038 reset asserted while SOLVED with a pending write -> next cycle in_port=8'hFF, solved=0, guess_count=0, and later guesses ignored until load_secret.
